serv_fetch_ctrl: RTL and testbench
==================================

SERV_FETCH_CTRL -- requirements
Module: serv_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, the number of FETCH cycles without ack before a bus error (range 1..65535).
REQ-003 SHALL have port i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port o_ibus_adr  out  32  fetch address; bits [1:0] always 0.
REQ-006 SHALL have port o_ibus_cyc  out  1  Wishbone cycle/strobe.
REQ-007 SHALL have port i_ibus_rdt  in  32  fetched word.
REQ-008 SHALL have port i_ibus_ack  in  1  Wishbone ack.
REQ-009 SHALL have port o_dec_rdt  out  30  latched instruction bits [31:2] to serv_decode i_wb_rdt.
REQ-010 SHALL have port o_dec_en  out  1  one-cycle decode strobe to serv_decode i_wb_en.
REQ-011 SHALL have port i_ebreak  in  1  registered o_ebreak from serv_decode.
REQ-012 SHALL have port i_next_pc  in  32  next PC from core; bits [1:0] ignored.
REQ-013 SHALL have port i_next_pc_vld  in  1  instruction retired, i_next_pc valid.
REQ-014 SHALL have port i_resume  in  1  leave HALT.
REQ-015 SHALL have port o_halted  out  1  controller in HALT.
REQ-016 SHALL have port o_bus_err  out  1  one-cycle fetch-timeout pulse.

Function
REQ-017 SHALL implement states BOOT, FETCH, ERR, DECODE, EXEC, HALT.
REQ-018 BOOT SHALL move to FETCH on the first cycle with i_rst_n=1.
REQ-019 FETCH SHALL assert o_ibus_cyc with o_ibus_adr stable until ack.
REQ-020 On i_ibus_ack in FETCH: o_dec_rdt <= i_ibus_rdt[31:2], go DECODE; o_ibus_cyc low next cycle.
REQ-021 DECODE SHALL last exactly one cycle with o_dec_en=1, then go EXEC; ack-to-o_dec_en latency = 1 cycle.
REQ-022 EXEC SHALL wait for i_next_pc_vld, then load o_ibus_adr <= {i_next_pc[31:2],2'b00} and go FETCH; o_ibus_cyc high the following cycle.
REQ-023 FETCH SHALL count cycles; after TIMEOUT consecutive cycles without ack, go ERR.
REQ-024 ERR SHALL last one cycle, o_ibus_cyc=0, o_bus_err=1, then re-enter FETCH at the same address with the counter cleared.
REQ-025 Ack and timeout in the same cycle: ack SHALL win; no o_bus_err.
REQ-026 i_ibus_ack outside FETCH and i_next_pc_vld outside EXEC SHALL be ignored.
REQ-027 o_dec_rdt SHALL hold its value until the next accepted ack.

Reset
REQ-028 While i_rst_n=0 at an edge: state=BOOT, o_ibus_adr=RESET_PC, o_ibus_cyc=0, o_dec_en=0, o_dec_rdt=0, o_bus_err=0, o_halted=0, timeout counter=0.
REQ-029 Reset mid-fetch SHALL drop o_ibus_cyc at that edge; the pending ack SHALL be discarded.

Configuration
REQ-030 Macro SERV_FETCH_HALT_EN defined: in EXEC with i_ebreak=1, i_next_pc_vld SHALL capture i_next_pc and go HALT (o_halted=1, o_ibus_cyc=0); i_resume in HALT SHALL go FETCH next cycle.
REQ-031 Macro undefined: HALT unreachable, o_halted tied 0, i_resume ignored, ebreak sequenced as a normal instruction.

Structure
REQ-032 Package serv_fetch_pkg SHALL hold the state enum and the state encoding width.
REQ-033 Timeout counter SHALL be sub-module serv_fetch_timer (clear, enable, expired).

Verification
REQ-034 Reset release, ack 3 cycles after cyc, rdt=32'h0010_0073 -> adr=0, o_dec_en one pulse 1 cycle after ack, o_dec_rdt=30'h0004_001C.
REQ-035 EXEC, i_next_pc=32'h0000_0107 with vld -> o_ibus_adr=32'h0000_0104, cyc high next cycle.
REQ-036 TIMEOUT=4, no ack -> o_bus_err high on cycle 5, cyc low one cycle, refetch same address.
REQ-037 TIMEOUT=4, ack on 4th FETCH cycle -> no o_bus_err, DECODE next.
REQ-038 HALT_EN, ebreak instruction, vld -> o_halted=1, cyc stays 0 for 10 cycles; i_resume -> fetch at captured PC.
REQ-039 i_rst_n low during FETCH -> cyc 0 next edge, late ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/serv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// serv_fetch_pkg
//   Shared definitions for the SERV instruction-fetch controller slice.
//   - STATE_W  : width of the fetch controller state encoding
//   - state_t  : fetch controller states
//   - TMR_W    : width of the fetch timeout counter (covers TIMEOUT up to 65535)
//   - word_align() : clears the byte-offset bits of a 32-bit address
// -----------------------------------------------------------------------------
package serv_fetch_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TMR_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ERR    = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/serv_fetch_timer.sv
// -----------------------------------------------------------------------------
// serv_fetch_timer
//   Counts consecutive enabled cycles and flags the cycle in which the count
//   of enabled cycles reaches TIMEOUT.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset, clears the count
//   i_clr      : synchronous clear (has priority over i_en)
//   i_en       : count this cycle
//   o_expired  : combinational, high in the TIMEOUT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module serv_fetch_timer
  import serv_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of already completed enabled cycles, so the
  // current cycle is the TIMEOUT-th one when r_cnt == TIMEOUT-1.
  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/serv_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// serv_fetch_ctrl
//   Instruction-fetch sequencer for a SERV-style core. Fetches one word over a
//   Wishbone-classic instruction bus, hands it to the decoder with a one-cycle
//   strobe, waits for the core to retire it, then fetches from the next PC.
//   A fetch that sees no ack for TIMEOUT cycles produces a one-cycle bus error
//   and is retried at the same address.
//
// Optional feature (macro SERV_FETCH_HALT_EN):
//   When defined, retiring an instruction while i_ebreak is high captures the
//   next PC and parks the controller in HALT until i_resume. When undefined,
//   ebreak retires like any other instruction and o_halted is tied low.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//   TIMEOUT  : FETCH cycles without ack before a bus error (1..65535)
// Ports:
//   i_clk          : clock, rising edge
//   i_rst_n        : synchronous active-low reset
//   o_ibus_adr     : fetch address, word aligned
//   o_ibus_cyc     : Wishbone cycle/strobe
//   i_ibus_rdt     : fetched word
//   i_ibus_ack     : Wishbone ack
//   o_dec_rdt      : latched instruction bits [31:2]
//   o_dec_en       : one-cycle decode strobe
//   i_ebreak       : decoder reports ebreak
//   i_next_pc      : next PC from core (bits [1:0] ignored)
//   i_next_pc_vld  : instruction retired, i_next_pc valid
//   i_resume       : leave HALT
//   o_halted       : controller is in HALT
//   o_bus_err      : one-cycle fetch timeout pulse
// -----------------------------------------------------------------------------
module serv_fetch_ctrl
  import serv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_dec_rdt,
  output logic        o_dec_en,
  input  logic        i_ebreak,
  input  logic [31:0] i_next_pc,
  input  logic        i_next_pc_vld,
  input  logic        i_resume,
  output logic        o_halted,
  output logic        o_bus_err
);

  state_t      r_state;
  logic [31:0] r_adr;
  logic        r_cyc;
  logic [29:0] r_rdt;
  logic        r_dec_en;
  logic        r_bus_err;
  logic        r_halted;

  logic w_in_fetch;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;
  logic w_unused;

  assign w_in_fetch = (r_state == ST_FETCH);
  // Ack in the same cycle as expiry keeps the timer disabled, so ack wins.
  assign w_tmr_en   = w_in_fetch && !i_ibus_ack;
  assign w_tmr_clr  = !w_in_fetch || i_ibus_ack;

  serv_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_BOOT;
      r_adr     <= word_align(RESET_PC);
      r_cyc     <= 1'b0;
      r_rdt     <= '0;
      r_dec_en  <= 1'b0;
      r_bus_err <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
          r_cyc   <= 1'b1;
        end

        ST_FETCH: begin
          if (i_ibus_ack) begin
            r_rdt    <= i_ibus_rdt[31:2];
            r_cyc    <= 1'b0;
            r_dec_en <= 1'b1;
            r_state  <= ST_DECODE;
          end else if (w_expired) begin
            r_cyc     <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= ST_ERR;
          end
        end

        ST_ERR: begin
          r_bus_err <= 1'b0;
          r_cyc     <= 1'b1;
          r_state   <= ST_FETCH;
        end

        ST_DECODE: begin
          r_dec_en <= 1'b0;
          r_state  <= ST_EXEC;
        end

        ST_EXEC: begin
          if (i_next_pc_vld) begin
            r_adr <= word_align(i_next_pc);
`ifdef SERV_FETCH_HALT_EN
            if (i_ebreak) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_cyc   <= 1'b1;
              r_state <= ST_FETCH;
            end
`else
            r_cyc   <= 1'b1;
            r_state <= ST_FETCH;
`endif
          end
        end

`ifdef SERV_FETCH_HALT_EN
        ST_HALT: begin
          if (i_resume) begin
            r_halted <= 1'b0;
            r_cyc    <= 1'b1;
            r_state  <= ST_FETCH;
          end
        end
`endif

        default: begin
          r_cyc    <= 1'b0;
          r_dec_en <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= ST_BOOT;
        end
      endcase
    end
  end

  assign o_ibus_adr = r_adr;
  assign o_ibus_cyc = r_cyc;
  assign o_dec_rdt  = r_rdt;
  assign o_dec_en   = r_dec_en;
  assign o_bus_err  = r_bus_err;

`ifdef SERV_FETCH_HALT_EN
  assign o_halted = r_halted;
  assign w_unused = ^i_ibus_rdt[1:0];
`else
  assign o_halted = 1'b0;
  assign w_unused = ^{i_ibus_rdt[1:0], i_ebreak, i_resume, r_halted};
`endif

endmodule

// File: tb/tb_serv_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serv_fetch_ctrl
//   Directed plus randomized bench for serv_fetch_ctrl with TIMEOUT=4.
//   The reference model is transaction level: the expected fetch address, the
//   latched instruction and the points where bus errors must occur are derived
//   from the fetch/retire rules, not from the controller's state machine.
// -----------------------------------------------------------------------------
module tb_serv_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned TMO      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [29:0] dec_rdt;
  logic        dec_en;
  logic        ebreak;
  logic [31:0] next_pc;
  logic        next_pc_vld;
  logic        resume;
  logic        halted;
  logic        bus_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] m_adr;
  logic [29:0] m_rdt;

  serv_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_ibus_adr    (ibus_adr),
    .o_ibus_cyc    (ibus_cyc),
    .i_ibus_rdt    (ibus_rdt),
    .i_ibus_ack    (ibus_ack),
    .o_dec_rdt     (dec_rdt),
    .o_dec_en      (dec_en),
    .i_ebreak      (ebreak),
    .i_next_pc     (next_pc),
    .i_next_pc_vld (next_pc_vld),
    .i_resume      (resume),
    .o_halted      (halted),
    .o_bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction fetch: d FETCH cycles without ack, then ack with word w.
  // Every TMO consecutive unacked cycles the model expects one error cycle
  // followed by a retry at the same address.
  task automatic do_fetch(input int unsigned d, input logic [31:0] w);
    int unsigned tot = 0;
    int unsigned run = 0;
    for (int k = 0; k < 64; k++) begin
      chk("fetch_cyc", {31'd0, ibus_cyc}, 32'd1);
      chk("fetch_adr", ibus_adr, m_adr);
      chk("fetch_err", {31'd0, bus_err}, 32'd0);
      // retire pulses outside EXEC must not move the address
      next_pc_vld = 1'($urandom);
      next_pc     = $urandom;
      if (tot == d) begin
        ibus_ack = 1'b1;
        ibus_rdt = w;
        step();
        ibus_ack    = 1'b0;
        ibus_rdt    = $urandom;
        next_pc_vld = 1'b0;
        m_rdt       = w[31:2];
        chk("dec_en_pulse", {31'd0, dec_en}, 32'd1);
        chk("cyc_after_ack", {31'd0, ibus_cyc}, 32'd0);
        chk("dec_rdt", {2'd0, dec_rdt}, {2'd0, m_rdt});
        chk("err_after_ack", {31'd0, bus_err}, 32'd0);
        // an ack during DECODE must be ignored
        ibus_ack = 1'($urandom);
        step();
        ibus_ack = 1'b0;
        chk("dec_en_single", {31'd0, dec_en}, 32'd0);
        chk("cyc_exec", {31'd0, ibus_cyc}, 32'd0);
        chk("dec_rdt_hold", {2'd0, dec_rdt}, {2'd0, m_rdt});
        return;
      end
      step();
      tot++;
      run++;
      if (run == TMO) begin
        chk("timeout_err", {31'd0, bus_err}, 32'd1);
        chk("timeout_cyc", {31'd0, ibus_cyc}, 32'd0);
        chk("timeout_adr", ibus_adr, m_adr);
        step();
        chk("err_single", {31'd0, bus_err}, 32'd0);
        run = 0;
      end
    end
  endtask

  // Execute phase: w idle cycles (with ignored acks), then retire with pc.
  task automatic do_exec(input int unsigned w, input logic [31:0] pc, input logic eb);
    next_pc_vld = 1'b0;
    for (int k = 0; k < int'(w); k++) begin
      ibus_ack = 1'($urandom);
      ibus_rdt = $urandom;
      step();
      ibus_ack = 1'b0;
      chk("exec_cyc", {31'd0, ibus_cyc}, 32'd0);
      chk("exec_adr", ibus_adr, m_adr);
      chk("exec_rdt", {2'd0, dec_rdt}, {2'd0, m_rdt});
    end
    next_pc     = pc;
    next_pc_vld = 1'b1;
    ebreak      = eb;
    step();
    next_pc_vld = 1'b0;
    ebreak      = 1'b0;
    m_adr       = {pc[31:2], 2'b00};
    chk("retire_adr", ibus_adr, m_adr);
`ifdef SERV_FETCH_HALT_EN
    if (eb) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_cyc", {31'd0, ibus_cyc}, 32'd0);
      for (int k = 0; k < 10; k++) begin
        next_pc_vld = 1'($urandom);
        next_pc     = $urandom;
        ibus_ack    = 1'($urandom);
        step();
        chk("halt_hold_cyc", {31'd0, ibus_cyc}, 32'd0);
        chk("halt_hold_flag", {31'd0, halted}, 32'd1);
        chk("halt_hold_adr", ibus_adr, m_adr);
      end
      next_pc_vld = 1'b0;
      ibus_ack    = 1'b0;
      resume      = 1'b1;
      step();
      resume = 1'b0;
      chk("resume_halted", {31'd0, halted}, 32'd0);
      chk("resume_cyc", {31'd0, ibus_cyc}, 32'd1);
    end else begin
      chk("retire_cyc", {31'd0, ibus_cyc}, 32'd1);
    end
`else
    chk("retire_cyc", {31'd0, ibus_cyc}, 32'd1);
    chk("never_halted", {31'd0, halted}, 32'd0);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    ibus_rdt    = '0;
    ibus_ack    = 1'b0;
    ebreak      = 1'b0;
    next_pc     = '0;
    next_pc_vld = 1'b0;
    resume      = 1'b0;
    m_adr       = {RESET_PC[31:2], 2'b00};
    m_rdt       = '0;

    // Reset state
    step();
    step();
    chk("rst_adr", ibus_adr, m_adr);
    chk("rst_cyc", {31'd0, ibus_cyc}, 32'd0);
    chk("rst_dec_en", {31'd0, dec_en}, 32'd0);
    chk("rst_dec_rdt", {2'd0, dec_rdt}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Release: first fetch at RESET_PC, ack after 3 cycles of cyc
    rst_n = 1'b1;
    step();
    do_fetch(2, 32'h0010_0073);
    chk("ebreak_word_rdt", {2'd0, dec_rdt}, 32'h0004_001C);
    do_exec(1, 32'h0000_0107, 1'b0);
    chk("pc_0104", ibus_adr, 32'h0000_0104);

    // Ack on the last allowed cycle, then a single timeout, then two timeouts
    do_fetch(TMO - 1, $urandom);
    do_exec(0, $urandom, 1'b0);
    do_fetch(TMO, $urandom);
    do_exec(2, $urandom, 1'b0);
    do_fetch(2 * TMO + 1, $urandom);

    // ebreak retirement
    do_exec(1, 32'h0000_2000, 1'b1);
    do_fetch(0, $urandom);
    do_exec(0, $urandom, 1'b0);

    // Randomized fetch/retire sequences
    for (int i = 0; i < 24; i++) begin
      do_fetch($urandom_range(0, 2 * TMO + 1), $urandom);
      do_exec($urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a fetch; an ack arriving during reset is dropped
    step();
    chk("midfetch_cyc", {31'd0, ibus_cyc}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_cyc", {31'd0, ibus_cyc}, 32'd0);
    chk("midrst_adr", ibus_adr, {RESET_PC[31:2], 2'b00});
    ibus_ack = 1'b1;
    ibus_rdt = 32'hDEAD_BEEF;
    step();
    ibus_ack = 1'b0;
    chk("late_ack_dec_en", {31'd0, dec_en}, 32'd0);
    chk("late_ack_rdt", {2'd0, dec_rdt}, 32'd0);
    chk("late_ack_cyc", {31'd0, ibus_cyc}, 32'd0);
    rst_n = 1'b1;
    m_adr = {RESET_PC[31:2], 2'b00};
    m_rdt = '0;
    step();
    do_fetch(1, 32'h1234_5678);
    do_exec(0, 32'h0000_0040, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
